// File: rtl/uart_line_buffer.sv
// uart_line_buffer
//
// Receive-store-transmit controller between the uart core and the debounce
// button path. Received bytes are case-converted (CASE_MODE) and stored in a
// circular FIFO. A rising edge on the debounced button drains the FIFO back
// out through the uart transmitter, one byte at a time. Bytes received while
// a drain is running are appended and sent in the same drain.
//
// Optional feature macro: LINEBUF_AUTOSEND_EN
//   When defined, a received byte equal to EOL_CHAR (raw, before conversion)
//   starts a drain one cycle later, exactly as a button edge would.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, >= 4
//   ADDR_W    log2(DEPTH)
//   CASE_MODE 0 pass-through, 1 lower->upper, 2 upper->lower
//   EOL_CHAR  end-of-line byte for the auto-send feature
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous active-high reset
//   btn_pressed     in   debounced button level
//   received        in   one-cycle pulse, rx_byte valid in the same cycle
//   rx_byte         in   received byte
//   is_transmitting in   uart transmitter busy
//   transmit        out  request uart to send tx_byte
//   tx_byte         out  byte to transmit (8'h00 while idle)
//   count           out  stored bytes, 0..DEPTH
//   empty           out  count == 0
//   full            out  count == DEPTH
//   overflow        out  sticky, a byte was dropped because the FIFO was full
//   busy            out  drain in progress

module uart_line_buffer #(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = 8,
    parameter int          CASE_MODE = 1,
    parameter logic [7:0]  EOL_CHAR  = 8'h0D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_pressed,
    input  logic              received,
    input  logic [7:0]        rx_byte,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_POP
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                btn_q;
    logic [7:0]          mem [DEPTH];

    logic                push;
    logic                pop;
    logic                start;

    // Case conversion only touches the letter range selected by CASE_MODE.
    function automatic logic [7:0] conv(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (CASE_MODE == 1 && b >= 8'h61 && b <= 8'h7A) begin
            r = b - 8'h20;
        end else if (CASE_MODE == 2 && b >= 8'h41 && b <= 8'h5A) begin
            r = b + 8'h20;
        end
        return r;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_byte  = busy ? mem[rd_ptr_q] : 8'h00;

    // full is judged on the pre-pop count, so a push while full is dropped
    // even if a pop happens in the same cycle.
    assign push = received & ~full;
    assign pop  = (state_q == S_POP);

`ifdef LINEBUF_AUTOSEND_EN
    // The EOL trigger is registered so it behaves like a start one cycle
    // after the byte, and fires even when the byte itself was dropped.
    logic eol_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            eol_q <= 1'b0;
        end else begin
            eol_q <= received & (rx_byte == EOL_CHAR);
        end
    end

    assign start = (btn_pressed & ~btn_q) | eol_q;
`else
    logic [7:0] unused_eol;
    assign unused_eol = EOL_CHAR;
    assign start      = btn_pressed & ~btn_q;
`endif

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Drain FSM; POP looks at the post-pop count so bytes pushed during the
    // drain keep it running.
    always_comb begin
        state_d  = state_q;
        transmit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !empty) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                transmit = 1'b1;
                if (is_transmitting) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!is_transmitting) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = (count_d == '0) ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A drop in the same cycle as a drain start still leaves overflow set,
    // since that byte is lost after the drain began.
    always_comb begin
        overflow_d = overflow_q;
        if (state_q == S_IDLE && state_d == S_WAIT) begin
            overflow_d = 1'b0;
        end
        if (received && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            btn_q      <= btn_pressed;
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= conv(rx_byte);
        end
    end

endmodule
